// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU wide sequencer: request opcodes, ALU FunSel codes, flag indices, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam logic [2:0] OP_SINGLE = 3'b000;
  localparam logic [2:0] OP_ADD64  = 3'b001;
  localparam logic [2:0] OP_LSL64  = 3'b010;
  localparam logic [2:0] OP_LSR64  = 3'b011;
  localparam logic [2:0] OP_ASR64  = 3'b100;

  // 32-bit ALU function selects used to build the 64-bit operations
  localparam logic [4:0] FS_ADD = 5'b10100;
  localparam logic [4:0] FS_ADC = 5'b10101;
  localparam logic [4:0] FS_LSL = 5'b11011;
  localparam logic [4:0] FS_LSR = 5'b11100;
  localparam logic [4:0] FS_ASR = 5'b11101;
  localparam logic [4:0] FS_ROR = 5'b11110;
  localparam logic [4:0] FS_ROL = 5'b11111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE2 = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CAP1   = 3'd3,
    ST_CAP2   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic op_is_wide(input logic [2:0] op);
    return (op == OP_ADD64) || (op == OP_LSL64) || (op == OP_LSR64) || (op == OP_ASR64);
  endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// Saturating counters of completed responses (all, and wide-only).
// Latency: counts update on the edge the response handshake completes.
// Backpressure: none; observes handshakes only.
module alu_seq_stats (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        done_i,
  input  logic        wide_i,
  output logic [15:0] stat_ops_o,
  output logic [15:0] stat_wide_o
);

  logic [15:0] ops_q, ops_d;
  logic [15:0] wide_q, wide_d;

  // Increment on each completed response, holding at all-ones
  always_comb begin
    ops_d  = ops_q;
    wide_d = wide_q;
    if (done_i && (ops_q != 16'hFFFF)) ops_d = ops_q + 16'd1;
    if (done_i && wide_i && (wide_q != 16'hFFFF)) wide_d = wide_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ops_q  <= '0;
      wide_q <= '0;
    end else begin
      ops_q  <= ops_d;
      wide_q <= wide_d;
    end
  end

  assign stat_ops_o  = ops_q;
  assign stat_wide_o = wide_q;

endmodule

// File: rtl/alu_wide_sequencer.sv
// Issue stage for a 32-bit ALU; builds 64-bit ADD/shift ops from two back-to-back ALU ops (ALU_SEQ_STATS_EN adds counters).
// Latency: resp_valid 1 cycle after accept (reserved), 2 (SINGLE), 3 (wide).
// Backpressure: one op in flight; req_ready low outside IDLE, response held until resp_ready.
module alu_wide_sequencer
  import alu_seq_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_funsel,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [31:0] AluOut,
  input  logic [3:0]  AluFlags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        resp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_wide
`endif
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a2_q, a2_d, b2_q, b2_d, h1_q, h1_d;
  logic [4:0]  fs2_q, fs2_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]  alu_fs_q, alu_fs_d;
  logic        alu_wf_q, alu_wf_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_result_q, resp_result_d;
  logic [3:0]  resp_flags_q, resp_flags_d;
  logic        resp_err_q, resp_err_d;

  logic        accept, resp_done, lo_first;
  logic [63:0] wide_res;

  assign accept    = req_valid && req_ready_q && (state_q == ST_IDLE);
  assign resp_done = resp_valid_q && resp_ready;
  // ADD and LSL run low half first; right shifts run high half first so the carry moves downward
  assign lo_first  = (op_q == OP_ADD64) || (op_q == OP_LSL64);
  assign wide_res  = lo_first ? {AluOut, h1_q} : {h1_q, AluOut};

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: op2 always issued the cycle right after op1 so the ALU carry chains
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_wide(req_op))        state_d = ST_ISSUE2;
          else if (req_op == OP_SINGLE)  state_d = ST_WAIT;
          else                           state_d = ST_RESP;
        end
      end
      ST_ISSUE2: state_d = ST_CAP1;
      ST_WAIT:   state_d = ST_CAP1;
      ST_CAP1:   state_d = op_is_wide(op_q) ? ST_CAP2 : ST_RESP;
      ST_CAP2:   state_d = ST_RESP;
      ST_RESP:   if (resp_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values; ALU operands hold when no op is issued
  always_comb begin
    op_d          = op_q;
    a2_d          = a2_q;
    b2_d          = b2_q;
    fs2_d         = fs2_q;
    h1_d          = h1_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_fs_d      = alu_fs_q;
    alu_wf_d      = 1'b0;
    req_ready_d   = (state_d == ST_IDLE);
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = req_op;
          case (req_op)
            OP_SINGLE: begin
              alu_a_d  = req_a[31:0];
              alu_b_d  = req_b[31:0];
              alu_fs_d = req_funsel;
              alu_wf_d = 1'b1;
            end
            OP_ADD64, OP_LSL64: begin
              alu_a_d  = req_a[31:0];
              alu_b_d  = req_b[31:0];
              alu_fs_d = (req_op == OP_ADD64) ? FS_ADD : FS_LSL;
              alu_wf_d = 1'b1;
              a2_d     = req_a[63:32];
              b2_d     = req_b[63:32];
              fs2_d    = (req_op == OP_ADD64) ? FS_ADC : FS_ROL;
            end
            OP_LSR64, OP_ASR64: begin
              alu_a_d  = req_a[63:32];
              alu_b_d  = req_b[63:32];
              alu_fs_d = (req_op == OP_LSR64) ? FS_LSR : FS_ASR;
              alu_wf_d = 1'b1;
              a2_d     = req_a[31:0];
              b2_d     = req_b[31:0];
              fs2_d    = FS_ROR;
            end
            default: begin
              resp_result_d = '0;
              resp_flags_d  = '0;
              resp_err_d    = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE2: begin
        alu_a_d  = a2_q;
        alu_b_d  = b2_q;
        alu_fs_d = fs2_q;
        alu_wf_d = 1'b1;
      end
      ST_CAP1: begin
        h1_d = AluOut;
        if (!op_is_wide(op_q)) begin
          resp_result_d = {32'd0, AluOut};
          resp_flags_d  = AluFlags;
          resp_err_d    = 1'b0;
          resp_valid_d  = 1'b1;
        end
      end
      ST_CAP2: begin
        resp_result_d         = wide_res;
        resp_flags_d[FLAG_Z]  = (wide_res == 64'd0);
        resp_flags_d[FLAG_C]  = AluFlags[FLAG_C];
        resp_flags_d[FLAG_N]  = wide_res[63];
        resp_flags_d[FLAG_V]  = AluFlags[FLAG_V];
        resp_err_d            = 1'b0;
        resp_valid_d          = 1'b1;
      end
      ST_RESP: begin
        // Reserved ops arrive here with valid still low; raise it one cycle later
        if (!resp_valid_q)   resp_valid_d = 1'b1;
        else if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q          <= '0;
      a2_q          <= '0;
      b2_q          <= '0;
      fs2_q         <= '0;
      h1_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_fs_q      <= '0;
      alu_wf_q      <= 1'b0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      op_q          <= op_d;
      a2_q          <= a2_d;
      b2_q          <= b2_d;
      fs2_q         <= fs2_d;
      h1_q          <= h1_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_fs_q      <= alu_fs_d;
      alu_wf_q      <= alu_wf_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign AluA        = alu_a_q;
  assign AluB        = alu_b_q;
  assign AluFunSel   = alu_fs_q;
  assign AluWF       = alu_wf_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk_i       (Clock),
    .rst_ni      (Reset),
    .done_i      (resp_done),
    .wide_i      (op_is_wide(op_q)),
    .stat_ops_o  (stat_ops),
    .stat_wide_o (stat_wide)
  );
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer paired with a behavioural 32-bit ALU.
// Latency: checks response arrival cycle per op class.
// Backpressure: exercises resp_ready stall and reset mid-operation.
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_funsel;
  logic [63:0] req_a, req_b;
  logic [31:0] AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [3:0]  AluFlags;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_result;
  logic [3:0]  resp_flags;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_wide;
`endif

  always #5 clk = ~clk;

  alu_wide_sequencer dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_funsel  (req_funsel),
    .req_a       (req_a),
    .req_b       (req_b),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluFunSel   (AluFunSel),
    .AluWF       (AluWF),
    .AluOut      (AluOut),
    .AluFlags    (AluFlags),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_err    (resp_err)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_wide   (stat_wide)
`endif
  );

  // Behavioural ALU: 1-clock latency, flags {Z,C,N,V} written only when WF is high
  function automatic logic [35:0] alu_eval(input logic [4:0] fs, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = a; c = 1'b0; v = 1'b0;
    case (fs)
      5'b10100: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                      v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'b10101: begin s = {1'b0, a} + {1'b0, b} + {32'd0, cin}; r = s[31:0]; c = s[32];
                      v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'b10110: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                      v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'b11011: begin r = {a[30:0], 1'b0}; c = a[31]; end
      5'b11100: begin r = {1'b0, a[31:1]}; c = a[0]; end
      5'b11101: begin r = {a[31], a[31:1]}; c = a[0]; end
      5'b11110: begin r = {cin, a[31:1]}; c = a[0]; end
      5'b11111: begin r = {a[30:0], cin}; c = a[31]; end
      default:  r = a;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  logic [35:0] alu_res;
  assign alu_res = alu_eval(AluFunSel, AluA, AluB, AluFlags[2]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AluOut   <= '0;
      AluFlags <= '0;
    end else begin
      AluOut <= alu_res[31:0];
      if (AluWF) AluFlags <= alu_res[35:32];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  fs;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  fl;
    logic        err;
    int          lat;
    int          wf;
  } vec_t;

  vec_t vecs[11];

  // Issue one request, measure latency and ALU write cycles, check response, optionally stall
  task automatic run_vec(input vec_t v, input string tag, input int stall);
    int  lat, wf, guard, bad;
    logic done;
    logic [63:0] held;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    check({tag, "_rdy_wait"}, 64'(guard < 20), 64'd1);
    req_op = v.op; req_funsel = v.fs; req_a = v.a; req_b = v.b; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; wf = 0; done = 1'b0;
    while (!done && lat < 16) begin
      @(negedge clk);
      if (lat == 0) check({tag, "_busy_rdy"}, 64'(req_ready), 64'd0);
      if (AluWF === 1'b1) wf++;
      if (resp_valid === 1'b1) done = 1'b1;
      else begin @(posedge clk); lat++; end
    end
    check({tag, "_timeout"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_wf_cycles"}, 64'(wf), 64'(v.wf));
    check({tag, "_result"}, resp_result, v.res);
    check({tag, "_flags"}, 64'(resp_flags), 64'(v.fl));
    check({tag, "_err"}, 64'(resp_err), 64'(v.err));
    if (stall > 0) begin
      bad = 0;
      held = resp_result;
      // offer a competing request while the response is stalled; it must not be taken
      req_op = 3'b000; req_funsel = 5'b10100; req_a = 64'd7; req_b = 64'd9; req_valid = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== held ||
            resp_flags !== v.fl || AluWF !== 1'b0) bad++;
      end
      req_valid = 1'b0;
      check({tag, "_stall_stable"}, 64'(bad), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_rdy"}, 64'(req_ready), 64'd1);
    check({tag, "_post_vld"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu_ab"}, {AluA, AluB}, 64'd0);
    check({tag, "_ctrl"}, 64'({AluFunSel, AluWF, resp_valid, resp_flags, resp_err, req_ready}), 64'd0);
    check({tag, "_result"}, resp_result, 64'd0);
  endtask

  initial begin
    //          op      fs        a                       b      result                  flags    err lat wf
    vecs[0]  = '{3'b001, 5'b00000, 64'h00000000_FFFFFFFF, 64'd1, 64'h00000001_00000000, 4'b0000, 1'b0, 3, 2};
    vecs[1]  = '{3'b001, 5'b00000, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 64'h80000000_00000000, 4'b0011, 1'b0, 3, 2};
    vecs[2]  = '{3'b010, 5'b00000, 64'h80000000_80000000, 64'd0, 64'h00000001_00000000, 4'b0100, 1'b0, 3, 2};
    vecs[3]  = '{3'b100, 5'b00000, 64'h80000000_00000001, 64'd0, 64'hC0000000_00000000, 4'b0110, 1'b0, 3, 2};
    vecs[4]  = '{3'b000, 5'b10110, 64'd5,                 64'd5, 64'd0,                 4'b1100, 1'b0, 2, 1};
    vecs[5]  = '{3'b101, 5'b00000, 64'h12345678_9ABCDEF0, 64'd3, 64'd0,                 4'b0000, 1'b1, 1, 0};
    vecs[6]  = '{3'b011, 5'b00000, 64'h00000003_00000001, 64'd0, 64'h00000001_80000000, 4'b0100, 1'b0, 3, 2};
    vecs[7]  = '{3'b001, 5'b00000, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'd0,                 4'b1100, 1'b0, 3, 2};
    vecs[8]  = '{3'b000, 5'b10100, 64'hDEADBEEF_FFFFFFFF, 64'd2, 64'd1,                 4'b0100, 1'b0, 2, 1};
    vecs[9]  = '{3'b100, 5'b00000, 64'h40000000_00000000, 64'd0, 64'h20000000_00000000, 4'b0000, 1'b0, 3, 2};
    vecs[10] = '{3'b111, 5'b00000, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 64'd0,                 4'b0000, 1'b1, 1, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_funsel = '0;
    req_a = '0; req_b = '0; resp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rel_rdy", 64'(req_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

    // response held under backpressure for 5 cycles
    run_vec(vecs[1], "stall", 5);

    // reset while the first half is being captured
    req_op = vecs[0].op; req_funsel = vecs[0].fs; req_a = vecs[0].a; req_b = vecs[0].b;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("midreset_rdy", 64'(req_ready), 64'd1);
    run_vec(vecs[3], "after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
